// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the EX stage.
// MUL (low 32) by shift-add; DIV/DIVU/REM by restoring division, one bit per cycle.
// Optional feature macro: MULDIV_DIV_EN enables the divider datapath. When it is
// undefined, DIV/DIVU/REM complete in two cycles with a zero result.
module ex_muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o
);

  localparam logic [1:0] OpMul = 2'b00;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;       // MUL accumulator / partial remainder
  logic [31:0] a_q, a_d;           // multiplicand / dividend shifting into quotient
  logic [31:0] b_q, b_d;           // multiplier / divisor
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] acc_nx, a_nx, b_nx, fin_res;

`ifdef MULDIV_DIV_EN
  localparam logic [1:0] OpDiv  = 2'b01;
  localparam logic [1:0] OpDivu = 2'b10;
  localparam logic [1:0] OpRem  = 2'b11;

  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [33:0] trial;
  logic        ge;

  // Partial remainder shifted left with the next dividend bit, minus divisor.
  assign trial = {1'b0, acc_q, a_q[31]} - {2'b00, b_q};
  assign ge    = ~trial[33];
`endif

  // Stall while an operation is being accepted or iterating; never during reset.
  assign busy_o = rst_n_i & (((state_q == StIdle) & start_i & ~flush_i) | (state_q == StCalc));
  assign done_o    = (state_q == StFin);
  assign result_o  = result_q;
  assign rd_addr_o = rd_out_q;

  // One iteration step of the shared shift datapath.
  always_comb begin
    acc_nx = acc_q;
    a_nx   = a_q << 1;
    b_nx   = b_q >> 1;
    if (b_q[0]) acc_nx = acc_q + a_q;
`ifdef MULDIV_DIV_EN
    if (op_q != OpMul) begin
      b_nx   = b_q;
      a_nx   = {a_q[30:0], ge};
      acc_nx = ge ? trial[31:0] : {acc_q[30:0], a_q[31]};
    end
`endif
  end

  // Sign-corrected result taken from the final iteration.
  always_comb begin
    fin_res = acc_nx;
`ifdef MULDIV_DIV_EN
    unique case (op_q)
      OpDiv:   fin_res = neg_q ? -a_nx : a_nx;
      OpDivu:  fin_res = a_nx;
      OpRem:   fin_res = neg_q ? -acc_nx : acc_nx;
      default: fin_res = acc_nx;
    endcase
`endif
  end

  // Next-state and datapath load/update decisions.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
`ifdef MULDIV_DIV_EN
    op_d     = op_q;
    neg_d    = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rd_d    = rd_addr_i;
          cnt_d   = 5'd31;
          acc_d   = '0;
          a_d     = rs1_i;
          b_d     = rs2_i;
          state_d = StCalc;
`ifdef MULDIV_DIV_EN
          op_d  = op_i;
          neg_d = 1'b0;
          if (op_i == OpDiv || op_i == OpRem) begin
            a_d   = rs1_i[31] ? -rs1_i : rs1_i;
            b_d   = rs2_i[31] ? -rs2_i : rs2_i;
            neg_d = (op_i == OpDiv) ? (rs1_i[31] ^ rs2_i[31]) : rs1_i[31];
          end
          if (op_i != OpMul) begin
            if (rs2_i == '0) begin
              result_d = (op_i == OpRem) ? rs1_i : '1;
              rd_out_d = rd_addr_i;
              state_d  = StFin;
            end else if (op_i != OpDivu && rs1_i == 32'h8000_0000 && rs2_i == '1) begin
              result_d = (op_i == OpDiv) ? 32'h8000_0000 : '0;
              rd_out_d = rd_addr_i;
              state_d  = StFin;
            end
          end
`else
          if (op_i != OpMul) begin
            result_d = '0;
            rd_out_d = rd_addr_i;
            state_d  = StFin;
          end
`endif
        end
      end
      StCalc: begin
        acc_d = acc_nx;
        a_d   = a_nx;
        b_d   = b_nx;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          result_d = fin_res;
          rd_out_d = rd_q;
          state_d  = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // An aborted operation must leave the presented result untouched.
    if (flush_i) begin
      state_d  = StIdle;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
`ifdef MULDIV_DIV_EN
      op_q     <= '0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
`ifdef MULDIV_DIV_EN
      op_q     <= op_d;
      neg_q    <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (directed + randomized operations).
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  ex_muldiv_unit dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result from the arithmetic definition of each operation.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
`ifdef MULDIV_DIV_EN
    case (op)
      2'b00: r = a * b;
      2'b01: r = (b == 0) ? 32'hFFFF_FFFF :
                 (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                 32'($signed(a) / $signed(b));
      2'b10: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: r = (b == 0) ? a :
                   (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 :
                   32'($signed(a) % $signed(b));
    endcase
`else
    r = (op == 2'b00) ? a * b : 32'h0;
`endif
    return r;
  endfunction

  // Cycle (counting the start cycle as 1) in which done_o is expected.
  function automatic int latency(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op == 2'b00) return 34;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 2;
    if (op != 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
`else
    return 2;
`endif
  endfunction

  // Issue one operation starting in the next cycle and check its whole timeline.
  // Returns at the negedge of the done cycle unless post_chk is set.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit post_chk);
    logic [31:0] exp;
    int lat, cyc, busy_bad;
    bit seen;
    exp = model(op, a, b);
    lat = latency(op, a, b);
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    @(negedge clk_i);
    chk({tag, "_busy_c1"}, 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_addr_i = 5'($urandom);
    cyc = 2; seen = 0; busy_bad = 0;
    while (!seen && cyc <= 40) begin
      @(negedge clk_i);
      if (busy_o !== 1'(cyc < lat)) busy_bad++;
      if (done_o === 1'b1) seen = 1;
      else begin
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(lat));
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_rd"}, 32'(rd_addr_o), 32'(rd));
    chk({tag, "_busy_profile"}, 32'(busy_bad), 32'd0);
    last_res = exp;
    last_rd  = rd;
    if (post_chk) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk({tag, "_done_1cyc"}, 32'(done_o), 32'd0);
      chk({tag, "_hold"}, result_o, exp);
    end
  endtask

  initial begin
    int seen_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    start_i = 0; flush_i = 0; op_i = 0; rs1_i = 0; rs2_i = 0; rd_addr_i = 0;
    rst_n_i = 1'b0;
    #22;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_rd", 32'(rd_addr_o), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'd5, 1);
    run_op("mul_neg1x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 5'd9, 0);
    run_op("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 5'd10, 0);
    run_op("rem_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd11, 1);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 5'd12, 1);
    run_op("rem_5_0", 2'b11, 32'd5, 32'd0, 5'd13, 1);
    run_op("div_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1);
    run_op("rem_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1);
    run_op("div_100_10", 2'b01, 32'd100, 32'd10, 5'd16, 1);
    run_op("mul4x5", 2'b00, 32'd4, 32'd5, 5'd17, 1);

    // Flush in cycle 10 of a long operation.
    @(posedge clk_i); #1;
`ifdef MULDIV_DIV_EN
    op_i = 2'b01;
`else
    op_i = 2'b00;
`endif
    start_i = 1'b1; rs1_i = 32'd1000; rs2_i = 32'd7; rd_addr_i = 5'd20;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (8) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_busy_c10", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    seen_done = 0;
    @(negedge clk_i);
    chk("flush_busy_c11", 32'(busy_o), 32'd0);
    repeat (30) begin
      @(negedge clk_i);
      if (done_o === 1'b1) seen_done++;
    end
    chk("flush_no_done", 32'(seen_done), 32'd0);
    chk("flush_result_kept", result_o, last_res);
    chk("flush_rd_kept", 32'(rd_addr_o), 32'(last_rd));
    run_op("mul3x3", 2'b00, 32'd3, 32'd3, 5'd21, 1);

    // Asynchronous reset in cycle 20 of a MUL.
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = 2'b00; rs1_i = 32'h1234; rs2_i = 32'h10; rd_addr_i = 5'd22;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (18) begin @(posedge clk_i); #1; end
    rst_n_i = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o === 1'b1 || busy_o === 1'b1) seen_done++;
    end
    chk("rst_idle_after", 32'(seen_done), 32'd0);

    // Randomized operations, including the special operand pairs.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op("rand", rop, ra, rb, 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
